uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8N1 UART transmitter between 4 byte-producing requesters, e.g. the CPU output port, debug dump and status reporter.
- Emits a one-cycle start pulse with a data byte to the transmitter.
- Holds off the next start for a full frame time, because the transmitter has no busy output.
- Supports multi-byte bursts: a requester keeps the grant until it marks a byte as last.

---
 rtl/uart_tx_arbiter_if.sv | 22 ++
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bus between the byte requesters and the shared-UART arbiter.
// The master side is the requester group, the slave side is the arbiter.
interface uart_tx_arbiter_if;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ack;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic [1:0]  grant_id;
   logic        busy;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ack, tx_start, tx_data, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ack, tx_start, tx_data, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between four byte
// requesters. It issues a one-cycle start pulse with a byte, then blocks the
// next start for a full frame time because the transmitter reports no busy.
// A requester keeps the grant across a burst until it sends a byte marked
// last, or until it stalls for LOCK_TO cycles.
module uart_tx_arbiter #(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 9600,
   parameter int FRAME_BITS = 10,
   parameter int LOCK_TO    = 65535
) (
   input logic            clk,
   input logic            rst_n,
   uart_tx_arbiter_if.slave bus
);

   localparam int          PERIOD     = CLK_FREQ / UART_BPS;
   localparam int          FRAME_CYC  = PERIOD * FRAME_BITS;
   localparam logic [19:0] FRAME_LAST = 20'(FRAME_CYC - 1);
   localparam logic [15:0] LOCK_LAST  = 16'(LOCK_TO - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [1:0]  grant_q, grant_d;
   logic [1:0]  rr_q, rr_d;
   logic        lock_q, lock_d;
   logic        last_q, last_d;
   logic [7:0]  byte_q, byte_d;
   logic [19:0] frame_q, frame_d;
   logic [15:0] to_q, to_d;

   logic        tx_start_q;
   logic [7:0]  tx_data_q;
   logic [3:0]  ack_q;
   logic        busy_q;

   logic [3:0]  cand_s;
   logic [1:0]  pick_s;

   // First set bit of v, searching start, start+1, ... modulo 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] start);
      logic [1:0] idx;
      logic [1:0] win;
      win = start;
      for (int k = 3; k >= 0; k--) begin
         idx = start + 2'(k);
         if (v[idx]) begin
            win = idx;
         end
      end
      return win;
   endfunction

   // While a burst owns the lock only the owner's request is eligible.
   always_comb begin
      if (lock_q) begin
         cand_s = bus.req_valid & (4'b0001 << grant_q);
         pick_s = grant_q;
      end else begin
         cand_s = bus.req_valid;
         pick_s = rr_pick(bus.req_valid, rr_q);
      end
   end

   // Next-state logic for the arbitration / frame-spacing sequencer.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      last_d  = last_q;
      byte_d  = byte_q;
      frame_d = frame_q;
      to_d    = to_q;
      case (state_q)
         ST_IDLE: begin
            if (cand_s != 4'd0) begin
               grant_d = pick_s;
               byte_d  = bus.req_data[{pick_s, 3'b000} +: 8];
               last_d  = bus.req_last[pick_s];
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            frame_d = 20'd0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (frame_q == FRAME_LAST) begin
               if (last_q) begin
                  rr_d    = grant_q + 2'd1;
                  lock_d  = 1'b0;
                  state_d = ST_IDLE;
               end else begin
                  lock_d  = 1'b1;
                  to_d    = 16'd0;
                  state_d = ST_HOLD;
               end
            end else begin
               frame_d = frame_q + 20'd1;
            end
         end
         ST_HOLD: begin
            if (cand_s != 4'd0) begin
               byte_d  = bus.req_data[{grant_q, 3'b000} +: 8];
               last_d  = bus.req_last[grant_q];
               to_d    = 16'd0;
               state_d = ST_SEND;
            end else if (to_q == LOCK_LAST) begin
               lock_d  = 1'b0;
               rr_d    = grant_q + 2'd1;
               state_d = ST_IDLE;
            end else begin
               to_d = to_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 2'd0;
         rr_q    <= 2'd0;
         lock_q  <= 1'b0;
         last_q  <= 1'b0;
         byte_q  <= 8'd0;
         frame_q <= 20'd0;
         to_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         lock_q  <= lock_d;
         last_q  <= last_d;
         byte_q  <= byte_d;
         frame_q <= frame_d;
         to_q    <= to_d;
      end
   end

   // Registered outputs decoded from the current state; tx_data only
   // changes together with a start pulse so the transmitter sees a stable byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
         ack_q      <= 4'd0;
         busy_q     <= 1'b0;
      end else begin
         tx_start_q <= (state_q == ST_SEND);
         busy_q     <= (state_q != ST_IDLE);
         if (state_q == ST_SEND) begin
            tx_data_q <= byte_q;
            ack_q     <= 4'b0001 << grant_q;
         end else begin
            tx_data_q <= tx_data_q;
            ack_q     <= 4'd0;
         end
      end
   end

   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.req_ack  = ack_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: requesters are modelled as byte queues,
// the expected grant order comes from a transaction-level round-robin model.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   uart_tx_arbiter_if bus();

   uart_tx_arbiter #(
      .CLK_FREQ  (1000),
      .UART_BPS  (100),
      .FRAME_BITS(10),
      .LOCK_TO   (20)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int busy_cnt = 0;
   int model_rr = 0;

   logic [8:0] rq [4][$];   // driver queues {last, data}
   logic [8:0] mq [4][$];   // model copy
   int         st_cyc [$];
   logic [7:0] st_data [$];
   logic [1:0] st_gid [$];
   int         exp_gid [$];
   logic [7:0] exp_data [$];
   logic [3:0] glitch = 4'd0;

   task automatic drive();
      logic [3:0]  v;
      logic [31:0] d;
      logic [3:0]  l;
      logic [8:0]  e;
      v = 4'd0; d = 32'd0; l = 4'd0;
      for (int i = 0; i < 4; i++) begin
         if (rq[i].size() > 0) begin
            e = rq[i][0];
            v[i] = 1'b1;
            d[8*i +: 8] = e[7:0];
            l[i] = e[8];
         end
      end
      bus.req_valid = v | glitch;
      bus.req_data  = d;
      bus.req_last  = l;
   endtask

   // One clock: sample at the falling edge, retire acked bytes, re-drive.
   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      total++;
      if (bus.tx_start) begin
         st_cyc.push_back(cyc);
         st_data.push_back(bus.tx_data);
         st_gid.push_back(bus.grant_id);
         if (bus.req_ack !== (4'b0001 << bus.grant_id)) begin
            bad++;
            $display("FAIL ack_with_start: ack=%b grant=%0d want one-hot of grant", bus.req_ack, bus.grant_id);
         end
      end else if (bus.req_ack !== 4'd0) begin
         bad++;
         $display("FAIL ack_without_start: ack=%b want 0000", bus.req_ack);
      end
      for (int i = 0; i < 4; i++) begin
         if (bus.req_ack[i] === 1'b1) begin
            if (rq[i].size() > 0) begin
               void'(rq[i].pop_front());
            end else begin
               bad++;
               $display("FAIL ack_to_idle_requester: req=%0d got ack, want none", i);
            end
         end
      end
      drive();
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (st_cyc.size() < n && k < budget) begin
         step();
         k++;
      end
      total++;
      if (st_cyc.size() < n) begin
         bad++;
         $display("FAIL start_timeout: got %0d starts want %0d", st_cyc.size(), n);
      end
   endtask

   task automatic push_req(input int i, input logic [7:0] d, input logic l);
      rq[i].push_back({l, d});
      mq[i].push_back({l, d});
   endtask

   // Transaction-level model: round robin from model_rr, a winner drains
   // its queue up to and including a last byte (or until it runs dry).
   task automatic model_run();
      int rr = model_rr;
      int g;
      logic [8:0] e;
      bit done;
      for (int n = 0; n < 64; n++) begin
         g = -1;
         for (int k = 0; k < 4; k++) begin
            if (g < 0 && mq[(rr + k) % 4].size() > 0) g = (rr + k) % 4;
         end
         if (g >= 0) begin
            done = 1'b0;
            while (!done) begin
               e = mq[g].pop_front();
               exp_gid.push_back(g);
               exp_data.push_back(e[7:0]);
               done = e[8] || (mq[g].size() == 0);
            end
            rr = (g + 1) % 4;
         end
      end
      model_rr = rr;
   endtask

   task automatic apply_reset();
      for (int i = 0; i < 4; i++) begin
         rq[i].delete();
         mq[i].delete();
      end
      glitch = 4'd0;
      drive();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      st_cyc.delete(); st_data.delete(); st_gid.delete();
      exp_gid.delete(); exp_data.delete();
      busy_cnt = 0;
      model_rr = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      step();
      total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
      total++; if (bus.tx_data !== 8'd0) begin bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
      total++; if (bus.req_ack !== 4'd0) begin bad++; $display("FAIL reset_ack: got %b want 0000", bus.req_ack); end
      total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", bus.grant_id); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
   endtask

   task automatic test_single();
      int c0;
      apply_reset();
      push_req(0, 8'h55, 1'b1);
      model_run();
      drive();
      c0 = cyc;
      wait_starts(1, 300);
      repeat (120) step();
      total++; if (st_data.size() < 1 || st_data[0] !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", (st_data.size() > 0) ? st_data[0] : 8'hxx); end
      total++; if (st_gid.size() < 1 || st_gid[0] !== 2'd0) begin bad++; $display("FAIL single_grant: want 0"); end
      total++; if (st_cyc.size() < 1 || st_cyc[0] != c0 + 2) begin bad++; $display("FAIL single_latency: got cycle %0d want %0d", (st_cyc.size() > 0) ? st_cyc[0] : -1, c0 + 2); end
      total++; if (busy_cnt != 101) begin bad++; $display("FAIL single_busy_len: got %0d want 101", busy_cnt); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle_after: busy=%b want 0", bus.busy); end
      // rr now points at requester 1, so it beats requester 0
      st_cyc.delete(); st_data.delete(); st_gid.delete();
      push_req(0, 8'h10, 1'b1);
      push_req(1, 8'h11, 1'b1);
      drive();
      wait_starts(1, 20);
      total++; if (st_gid.size() < 1 || st_gid[0] !== 2'd1) begin bad++; $display("FAIL single_rr_next: got %0d want 1", (st_gid.size() > 0) ? st_gid[0] : 2'bxx); end
   endtask

   task automatic test_contention();
      apply_reset();
      for (int i = 0; i < 4; i++) push_req(i, 8'hA0 + 8'(i), 1'b1);
      model_run();
      drive();
      wait_starts(4, 600);
      for (int k = 0; k < 4 && k < st_gid.size(); k++) begin
         total++;
         if (st_gid[k] !== 2'(exp_gid[k]) || st_data[k] !== exp_data[k]) begin
            bad++;
            $display("FAIL contention_order[%0d]: got req%0d/%h want req%0d/%h", k, st_gid[k], st_data[k], exp_gid[k], exp_data[k]);
         end
         if (k > 0) begin
            total++;
            if (st_cyc[k] - st_cyc[k-1] != 102) begin
               bad++;
               $display("FAIL contention_spacing[%0d]: got %0d want 102", k, st_cyc[k] - st_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_burst_lock();
      logic [7:0] want_d [4];
      int         want_g [4];
      want_d = '{8'h11, 8'h22, 8'h33, 8'h44};
      want_g = '{2, 2, 2, 0};
      apply_reset();
      push_req(2, 8'h11, 1'b0);
      push_req(2, 8'h22, 1'b0);
      push_req(2, 8'h33, 1'b1);
      drive();
      wait_starts(1, 20);
      push_req(0, 8'h44, 1'b1);
      drive();
      wait_starts(4, 600);
      for (int k = 0; k < 4 && k < st_gid.size(); k++) begin
         total++;
         if (st_gid[k] !== 2'(want_g[k]) || st_data[k] !== want_d[k]) begin
            bad++;
            $display("FAIL burst_order[%0d]: got req%0d/%h want req%0d/%h", k, st_gid[k], st_data[k], want_g[k], want_d[k]);
         end
         if (k > 0) begin
            total++;
            if (st_cyc[k] - st_cyc[k-1] < 101 || st_cyc[k] - st_cyc[k-1] > 102) begin
               bad++;
               $display("FAIL burst_spacing[%0d]: got %0d want 101..102", k, st_cyc[k] - st_cyc[k-1]);
            end
         end
      end
   endtask

   task automatic test_lock_timeout();
      apply_reset();
      push_req(1, 8'h61, 1'b0);
      push_req(3, 8'h63, 1'b1);
      model_run();
      drive();
      wait_starts(2, 400);
      for (int k = 0; k < 2 && k < st_gid.size(); k++) begin
         total++;
         if (st_gid[k] !== 2'(exp_gid[k]) || st_data[k] !== exp_data[k]) begin
            bad++;
            $display("FAIL timeout_order[%0d]: got req%0d/%h want req%0d/%h", k, st_gid[k], st_data[k], exp_gid[k], exp_data[k]);
         end
      end
      total++;
      if (st_cyc.size() < 2 || st_cyc[1] - st_cyc[0] != 122) begin
         bad++;
         $display("FAIL timeout_spacing: got %0d want 122", (st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : -1);
      end
      total++; if (bus.grant_id !== 2'd3) begin bad++; $display("FAIL timeout_grant: got %0d want 3", bus.grant_id); end
   endtask

   task automatic test_reset_mid_frame();
      int rel;
      apply_reset();
      push_req(1, 8'h71, 1'b1);
      drive();
      wait_starts(1, 20);
      repeat (105) step();
      push_req(2, 8'h72, 1'b1);
      drive();
      wait_starts(2, 20);
      repeat (50) step();
      push_req(0, 8'hC0, 1'b1);
      push_req(3, 8'hC3, 1'b1);
      rst_n = 1'b0;
      #1;
      total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL midreset_tx_start: got %b want 0", bus.tx_start); end
      total++; if (bus.tx_data !== 8'd0) begin bad++; $display("FAIL midreset_tx_data: got %h want 00", bus.tx_data); end
      total++; if (bus.req_ack !== 4'd0) begin bad++; $display("FAIL midreset_ack: got %b want 0000", bus.req_ack); end
      total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL midreset_grant: got %0d want 0", bus.grant_id); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
      repeat (3) step();
      rst_n = 1'b1;
      rel = cyc;
      st_cyc.delete(); st_data.delete(); st_gid.delete();
      wait_starts(1, 20);
      total++;
      if (st_gid.size() < 1 || st_gid[0] !== 2'd0 || st_data[0] !== 8'hC0 || st_cyc[0] != rel + 2) begin
         bad++;
         $display("FAIL midreset_restart: got req%0d/%h at +%0d want req0/c0 at +2",
                  (st_gid.size() > 0) ? st_gid[0] : 2'bxx, (st_data.size() > 0) ? st_data[0] : 8'hxx,
                  (st_cyc.size() > 0) ? st_cyc[0] - rel : -1);
      end
   endtask

   task automatic test_withdrawal();
      apply_reset();
      push_req(0, 8'h3C, 1'b1);
      drive();
      wait_starts(1, 20);
      repeat (20) step();
      glitch = 4'b0010;
      drive();
      step();
      glitch = 4'd0;
      drive();
      repeat (150) step();
      total++; if (st_cyc.size() != 1) begin bad++; $display("FAIL withdraw_starts: got %0d want 1", st_cyc.size()); end
      total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL withdraw_grant: got %0d want 0", bus.grant_id); end
   endtask

   task automatic test_random();
      int n;
      int nb;
      for (int it = 0; it < 3; it++) begin
         apply_reset();
         for (int i = 0; i < 4; i++) begin
            nb = $urandom_range(0, 4);
            for (int j = 0; j < nb; j++) begin
               push_req(i, 8'($urandom), (j == nb - 1) ? 1'b1 : 1'($urandom_range(0, 1)));
            end
         end
         if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 && rq[3].size() == 0) begin
            push_req(0, 8'h5A, 1'b1);
         end
         model_run();
         drive();
         n = exp_gid.size();
         wait_starts(n, n * 110 + 50);
         for (int k = 0; k < n && k < st_gid.size(); k++) begin
            total++;
            if (st_gid[k] !== 2'(exp_gid[k]) || st_data[k] !== exp_data[k]) begin
               bad++;
               $display("FAIL random_order[%0d.%0d]: got req%0d/%h want req%0d/%h", it, k, st_gid[k], st_data[k], exp_gid[k], exp_data[k]);
            end
            if (k > 0) begin
               total++;
               if (st_cyc[k] - st_cyc[k-1] < 101 || st_cyc[k] - st_cyc[k-1] > 102) begin
                  bad++;
                  $display("FAIL random_spacing[%0d.%0d]: got %0d want 101..102", it, k, st_cyc[k] - st_cyc[k-1]);
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      glitch = 4'd0;
      drive();
      test_reset();
      test_single();
      test_contention();
      test_burst_lock();
      test_lock_timeout();
      test_reset_mid_frame();
      test_withdrawal();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
